// File: rtl/delay_sram_pkg.sv
// Shared types and helpers for the delay-line SRAM controller.
// Optional feature macro: DELAY_SRAM_RR_ARB_EN (round-robin arbitration).
package delay_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_WR_PULSE = 3'd2,
    ST_WR_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Channel select encoding used by the arbiter and the last-served register.
  localparam logic CH_READ  = 1'b0;
  localparam logic CH_WRITE = 1'b1;

  // Width of the shared wait-state counter: enough to hold the larger wait count.
  function automatic int wait_cnt_width(input int rd_ws, input int wr_ws);
    int max_ws;
    max_ws = (rd_ws > wr_ws) ? rd_ws : wr_ws;
    return $clog2(max_ws + 1);
  endfunction

endpackage

// File: rtl/delay_sram_wait_counter.sv
// Loadable down-counter with a zero flag, shared by the read-wait and
// write-pulse phases of the SRAM controller.
module delay_sram_wait_counter
  import delay_sram_pkg::*;
#(
  parameter int CNT_W = wait_cnt_width(2, 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load takes precedence over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/delay_sram_controller.sv
// Single-port asynchronous SRAM controller behind the delay-line buffer
// manager. Level-held read/write requests are range-checked, arbitrated and
// answered with one-cycle ready/invalid pulses. Each channel carries an armed
// flag so a request still held high after completion is not served again.
// Handshake: a request is held high until its ready or invalid pulse; the
// channel is re-armed by any cycle in which its request is sampled low.
// Optional feature macro: DELAY_SRAM_RR_ARB_EN selects round-robin on a
// read/write tie; without it a write wins the tie.
module delay_sram_controller
  import delay_sram_pkg::*;
#(
  parameter int data_width        = 16,
  parameter int sram_addr_width   = 12,
  parameter int sram_capacity     = 8096,
  parameter int read_wait_states  = 2,
  parameter int write_wait_states = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_sram_read,
  input  logic                       req_sram_write,
  input  logic [sram_addr_width-1:0] req_sram_read_addr,
  input  logic [sram_addr_width-1:0] req_sram_write_addr,
  input  logic [data_width-1:0]      data_to_sram,
  output logic                       sram_read_ready,
  output logic                       sram_write_ready,
  output logic                       sram_read_invalid,
  output logic                       sram_write_invalid,
  output logic [data_width-1:0]      data_from_sram,
  output logic [sram_addr_width-1:0] sram_addr,
  output logic [data_width-1:0]      sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [data_width-1:0]      sram_dq_in,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output state_e                     dbg_state_o,
  output logic [1:0]                 dbg_armed_o
);

  localparam int               CNT_W   = wait_cnt_width(read_wait_states, write_wait_states);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(read_wait_states - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(write_wait_states - 1);
  localparam logic [31:0]      CAP32   = 32'(sram_capacity);

  state_e                     state_q, state_d;
  logic                       armed_rd_q, armed_rd_d;
  logic                       armed_wr_q, armed_wr_d;
  logic [sram_addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]      dq_out_q, dq_out_d;
  logic                       dq_oe_q, dq_oe_d;
  logic                       ce_n_q, ce_n_d;
  logic                       oe_n_q, oe_n_d;
  logic                       we_n_q, we_n_d;
  logic [data_width-1:0]      rdata_q, rdata_d;
  logic                       rd_rdy_q, rd_rdy_d;
  logic                       wr_rdy_q, wr_rdy_d;
  logic                       rd_inv_q, rd_inv_d;
  logic                       wr_inv_q, wr_inv_d;
`ifdef DELAY_SRAM_RR_ARB_EN
  logic                       last_q, last_d;
`endif

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             sel;

  logic rd_in_range, wr_in_range;
  logic rd_elig, wr_elig;
  logic rd_ok, wr_ok;

  // Unsigned range check, zero-extended to 32 bits.
  assign rd_in_range = (32'(req_sram_read_addr) < CAP32);
  assign wr_in_range = (32'(req_sram_write_addr) < CAP32);
  assign rd_elig     = req_sram_read && armed_rd_q;
  assign wr_elig     = req_sram_write && armed_wr_q;
  assign rd_ok       = rd_elig && rd_in_range;
  assign wr_ok       = wr_elig && wr_in_range;

  delay_sram_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state, strobe and response logic; everything holds unless changed.
  always_comb begin
    state_d      = state_q;
    armed_rd_d   = armed_rd_q;
    armed_wr_d   = armed_wr_q;
    addr_d       = addr_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = dq_oe_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    rdata_d      = rdata_q;
    rd_rdy_d     = 1'b0;
    wr_rdy_d     = 1'b0;
    rd_inv_d     = 1'b0;
    wr_inv_d     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    sel          = CH_WRITE;
`ifdef DELAY_SRAM_RR_ARB_EN
    last_d       = last_q;
`endif

    // A low request re-arms its channel.
    if (!req_sram_read)  armed_rd_d = 1'b1;
    if (!req_sram_write) armed_wr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Out-of-range requests are rejected without touching the SRAM.
        if (rd_elig && !rd_in_range) begin
          rd_inv_d   = 1'b1;
          armed_rd_d = 1'b0;
        end
        if (wr_elig && !wr_in_range) begin
          wr_inv_d   = 1'b1;
          armed_wr_d = 1'b0;
        end
`ifdef DELAY_SRAM_RR_ARB_EN
        if (rd_ok && wr_ok) sel = (last_q == CH_WRITE) ? CH_READ : CH_WRITE;
        else                sel = wr_ok ? CH_WRITE : CH_READ;
`else
        sel = wr_ok ? CH_WRITE : CH_READ;
`endif
        if (rd_ok || wr_ok) begin
`ifdef DELAY_SRAM_RR_ARB_EN
          last_d = sel;
`endif
          if (sel == CH_WRITE) begin
            armed_wr_d   = 1'b0;
            addr_d       = req_sram_write_addr;
            dq_out_d     = data_to_sram;
            dq_oe_d      = 1'b1;
            ce_n_d       = 1'b0;
            we_n_d       = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = WR_LOAD;
            state_d      = ST_WR_PULSE;
          end else begin
            armed_rd_d   = 1'b0;
            addr_d       = req_sram_read_addr;
            dq_oe_d      = 1'b0;
            ce_n_d       = 1'b0;
            oe_n_d       = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = RD_LOAD;
            state_d      = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_zero) begin
          rdata_d  = sram_dq_in;
          oe_n_d   = 1'b1;
          ce_n_d   = 1'b1;
          rd_rdy_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          we_n_d  = 1'b1;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        // Address and data stayed driven one cycle past we_n for hold time.
        ce_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        wr_rdy_d = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        // Bus turnaround; nothing is accepted here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      armed_rd_q <= 1'b1;
      armed_wr_q <= 1'b1;
      addr_q     <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      rdata_q    <= '0;
      rd_rdy_q   <= 1'b0;
      wr_rdy_q   <= 1'b0;
      rd_inv_q   <= 1'b0;
      wr_inv_q   <= 1'b0;
`ifdef DELAY_SRAM_RR_ARB_EN
      last_q     <= CH_WRITE;
`endif
    end else begin
      state_q    <= state_d;
      armed_rd_q <= armed_rd_d;
      armed_wr_q <= armed_wr_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      rdata_q    <= rdata_d;
      rd_rdy_q   <= rd_rdy_d;
      wr_rdy_q   <= wr_rdy_d;
      rd_inv_q   <= rd_inv_d;
      wr_inv_q   <= wr_inv_d;
`ifdef DELAY_SRAM_RR_ARB_EN
      last_q     <= last_d;
`endif
    end
  end

  assign sram_read_ready    = rd_rdy_q;
  assign sram_write_ready   = wr_rdy_q;
  assign sram_read_invalid  = rd_inv_q;
  assign sram_write_invalid = wr_inv_q;
  assign data_from_sram     = rdata_q;
  assign sram_addr          = addr_q;
  assign sram_dq_out        = dq_out_q;
  assign sram_dq_oe         = dq_oe_q;
  assign sram_ce_n          = ce_n_q;
  assign sram_oe_n          = oe_n_q;
  assign sram_we_n          = we_n_q;
  assign dbg_state_o        = state_q;
  assign dbg_armed_o        = {armed_wr_q, armed_rd_q};

endmodule

// File: tb/tb_delay_sram_controller.sv
// Testbench for delay_sram_controller: directed vector table plus hand-written
// sequences for reset during a write and simultaneous read/write requests.
// The capacity is set to 4000 (0xFA0) so the out-of-range boundary lies inside
// the 12-bit address space; 8096 would leave every address valid.
module tb_delay_sram_controller;
  import delay_sram_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int CAP = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req_sram_read, req_sram_write;
  logic [AW-1:0] req_sram_read_addr, req_sram_write_addr;
  logic [DW-1:0] data_to_sram;
  logic          sram_read_ready, sram_write_ready;
  logic          sram_read_invalid, sram_write_invalid;
  logic [DW-1:0] data_from_sram;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  state_e        dbg_state;
  logic [1:0]    dbg_armed;

  delay_sram_controller #(
    .data_width        (DW),
    .sram_addr_width   (AW),
    .sram_capacity     (CAP),
    .read_wait_states  (2),
    .write_wait_states (1)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_sram_read       (req_sram_read),
    .req_sram_write      (req_sram_write),
    .req_sram_read_addr  (req_sram_read_addr),
    .req_sram_write_addr (req_sram_write_addr),
    .data_to_sram        (data_to_sram),
    .sram_read_ready     (sram_read_ready),
    .sram_write_ready    (sram_write_ready),
    .sram_read_invalid   (sram_read_invalid),
    .sram_write_invalid  (sram_write_invalid),
    .data_from_sram      (data_from_sram),
    .sram_addr           (sram_addr),
    .sram_dq_out         (sram_dq_out),
    .sram_dq_oe          (sram_dq_oe),
    .sram_dq_in          (sram_dq_in),
    .sram_ce_n           (sram_ce_n),
    .sram_oe_n           (sram_oe_n),
    .sram_we_n           (sram_we_n),
    .dbg_state_o         (dbg_state),
    .dbg_armed_o         (dbg_armed)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  always @(negedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  end

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read-data check against the head of the expected queue.
  task automatic check_rdata(input string name);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unexpected read data %0h expected none", name, data_from_sram);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(data_from_sram), 32'(e));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_inv;
    logic [DW-1:0] exp_rd;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  // Holds one request for 8 cycles (several cycles past completion) and
  // checks pulse timing, pulse count, strobe activity and read data.
  task automatic run_vec(input vec_t v, input string tag);
    int   first_k = 0;
    int   pulses  = 0;
    int   stray   = 0;
    int   ce_c    = 0;
    int   oe_c    = 0;
    int   we_c    = 0;
    int   busy_c  = 0;
    logic rdy, inv;
    @(posedge clk); #1;
    if (v.is_wr) begin
      req_sram_write      = 1'b1;
      req_sram_write_addr = v.addr;
      data_to_sram        = v.data;
    end else begin
      req_sram_read      = 1'b1;
      req_sram_read_addr = v.addr;
    end
    if (!v.is_wr && !v.exp_inv) exp_q.push_back(v.exp_rd);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rdy = v.is_wr ? sram_write_ready : sram_read_ready;
      inv = v.is_wr ? sram_write_invalid : sram_read_invalid;
      if ((rdy || inv) && first_k == 0) first_k = k;
      if (v.exp_inv) begin
        if (inv) pulses++;
        if (rdy) stray++;
      end else begin
        if (rdy) pulses++;
        if (inv) stray++;
      end
      if (!sram_ce_n) ce_c++;
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) we_c++;
      if (dbg_state != ST_IDLE) busy_c++;
      if (rdy && !v.is_wr) check_rdata({tag, " rdata"});
    end
    @(posedge clk); #1;
    req_sram_read  = 1'b0;
    req_sram_write = 1'b0;
    @(posedge clk); #1;
    check({tag, " latency"}, 32'(first_k), v.exp_inv ? 32'd2 : 32'd4);
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " stray"}, 32'(stray), 32'd0);
    check({tag, " ce_cycles"}, 32'(ce_c), v.exp_inv ? 32'd0 : 32'd2);
    check({tag, " oe_cycles"}, 32'(oe_c), (!v.exp_inv && !v.is_wr) ? 32'd2 : 32'd0);
    check({tag, " we_cycles"}, 32'(we_c), (!v.exp_inv && v.is_wr) ? 32'd1 : 32'd0);
    if (v.exp_inv) check({tag, " stays_idle"}, 32'(busy_c), 32'd0);
  endtask

  // Watchdog: the sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   rd_k, wr_k, rd_p, wr_p, wr_rdy_after;
    logic exp_read_first;
    vec_t v_final;

`ifdef DELAY_SRAM_RR_ARB_EN
    exp_read_first = 1'b1;
`else
    exp_read_first = 1'b0;
`endif

    reset               = 1'b0;
    req_sram_read       = 1'b0;
    req_sram_write      = 1'b0;
    req_sram_read_addr  = '0;
    req_sram_write_addr = '0;
    data_to_sram        = '0;
    pre_we              = 1'b0;
    pre_addr            = '0;
    pre_data            = '0;

    //         is_wr  addr     data      inv   exp_rd
    vecs[0] = '{1'b0, 12'h010, 16'h0000, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b1, 12'h7FF, 16'h1234, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 12'h7FF, 16'h0000, 1'b0, 16'h1234};
    vecs[3] = '{1'b0, 12'hFA0, 16'h0000, 1'b1, 16'h0000};
    vecs[4] = '{1'b1, 12'hFA0, 16'hCAFE, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 12'hF9F, 16'hA5A5, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 12'hF9F, 16'h0000, 1'b0, 16'hA5A5};
    vecs[7] = '{1'b1, 12'hFFF, 16'h5A5A, 1'b1, 16'h0000};
    vecs[8] = '{1'b0, 12'h000, 16'h0000, 1'b0, 16'h0F0F};
    vecs[9] = '{1'b0, 12'hFFF, 16'h0000, 1'b1, 16'h0000};

    // Preload the SRAM model while the DUT is held in reset.
    repeat (2) @(posedge clk);
    #1;
    pre_we = 1'b1; pre_addr = 12'h010; pre_data = 16'hBEEF;
    @(posedge clk); #1;
    pre_addr = 12'h000; pre_data = 16'h0F0F;
    @(posedge clk); #1;
    pre_we = 1'b0;

    // Reset values.
    @(negedge clk);
    check("rst pulses", {28'd0, sram_read_ready, sram_write_ready, sram_read_invalid, sram_write_invalid}, 32'd0);
    check("rst data_from_sram", 32'(data_from_sram), 32'd0);
    check("rst sram_addr", 32'(sram_addr), 32'd0);
    check("rst sram_dq_out", 32'(sram_dq_out), 32'd0);
    check("rst sram_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst armed", 32'(dbg_armed), 32'd3);
    @(posedge clk); #1;
    reset = 1'b1;

    // Table-driven transactions.
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted during WR_PULSE.
    @(posedge clk); #1;
    req_sram_write      = 1'b1;
    req_sram_write_addr = 12'h100;
    data_to_sram        = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    check("midrst we_n low", 32'(sram_we_n), 32'd0);
    check("midrst in wr_pulse", 32'(dbg_state), 32'(ST_WR_PULSE));
    reset          = 1'b0;
    req_sram_write = 1'b0;
    @(negedge clk);
    check("midrst strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    check("midrst dq_oe", 32'(sram_dq_oe), 32'd0);
    check("midrst state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst armed", 32'(dbg_armed), 32'd3);
    check("midrst wr_ready", 32'(sram_write_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    wr_rdy_after = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sram_write_ready) wr_rdy_after++;
    end
    check("midrst no_ready", 32'(wr_rdy_after), 32'd0);

    // Simultaneous valid read and write; last-served is write after reset.
    rd_k = 0; wr_k = 0; rd_p = 0; wr_p = 0;
    @(posedge clk); #1;
    req_sram_read       = 1'b1;
    req_sram_read_addr  = 12'h010;
    req_sram_write      = 1'b1;
    req_sram_write_addr = 12'h020;
    data_to_sram        = 16'h5555;
    exp_q.push_back(16'hBEEF);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 2) check("tie winner strobes", {30'd0, sram_we_n, sram_oe_n}, exp_read_first ? 32'd2 : 32'd1);
      if (sram_read_ready) begin
        rd_p++;
        if (rd_k == 0) rd_k = k;
        check_rdata("tie rdata");
      end
      if (sram_write_ready) begin
        wr_p++;
        if (wr_k == 0) wr_k = k;
      end
      @(posedge clk); #1;
      if (rd_k != 0) req_sram_read = 1'b0;
      if (wr_k != 0) req_sram_write = 1'b0;
    end
    req_sram_read  = 1'b0;
    req_sram_write = 1'b0;
    check("tie read ready cycle", 32'(rd_k), exp_read_first ? 32'd4 : 32'd8);
    check("tie write ready cycle", 32'(wr_k), exp_read_first ? 32'd8 : 32'd4);
    check("tie read pulses", 32'(rd_p), 32'd1);
    check("tie write pulses", 32'(wr_p), 32'd1);

    // The tied write must have landed.
    v_final = '{1'b0, 12'h020, 16'h0000, 1'b0, 16'h5555};
    run_vec(v_final, "final");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
